// File: rtl/fft_pkg.sv
// Shared definitions for the R2^2 SDF FFT datapath blocks.
//   ROUND_TRUNC / ROUND_CONV : rounding mode selectors
//   cmul_state_e             : time-shared twiddle multiplier sequence
//   cmul_prod_w()            : product width for DATA x TWIDDLE operands
package fft_pkg;

    localparam int ROUND_TRUNC = 0;
    localparam int ROUND_CONV  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MF   = 2'd1,
        ST_MR   = 2'd2,
        ST_MI   = 2'd3
    } cmul_state_e;

    // A (DATA+1)-bit difference times a TWIDDLE-bit coefficient, or a
    // DATA-bit sample times a (TWIDDLE+1)-bit sum, both fit in DATA+TWIDDLE+1.
    function automatic int cmul_prod_w(input int data_w, input int twid_w);
        return data_w + twid_w + 1;
    endfunction

endpackage

// File: rtl/fft_round_sat.sv
// Rescale a P_W-bit product by SH bits, round, and clamp to D_W bits.
//   in_i  : P_W-bit signed full-precision value
//   z_o   : D_W-bit signed result
//   sat_o : high when z_o was clamped
// ROUND selects floor (ROUND_TRUNC) or round-half-to-even (ROUND_CONV).
module fft_round_sat
    import fft_pkg::*;
#(
    parameter int P_W   = 36,
    parameter int D_W   = 25,
    parameter int SH    = 9,
    parameter int ROUND = ROUND_CONV
) (
    input  logic signed [P_W-1:0] in_i,
    output logic signed [D_W-1:0] z_o,
    output logic                  sat_o
);

    // One spare bit so the round-up increment can never wrap.
    localparam int Q_W = P_W - SH + 1;
    localparam logic [SH-1:0] HALF = {1'b1, {(SH-1){1'b0}}};
    localparam logic signed [Q_W-1:0] MAXV = {{(Q_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
    localparam logic signed [Q_W-1:0] MINV = {{(Q_W-D_W+1){1'b1}}, {(D_W-1){1'b0}}};

    logic signed [Q_W-1:0] q;
    logic signed [Q_W-1:0] qr;
    logic [SH-1:0]         frac;
    logic                  up;

    always_comb begin
        q    = Q_W'(in_i >>> SH);
        frac = in_i[SH-1:0];
        up   = (ROUND == ROUND_CONV) && ((frac > HALF) || ((frac == HALF) && q[0]));
        qr   = q + {{(Q_W-1){1'b0}}, up};
        if (qr > MAXV) begin
            z_o   = MAXV[D_W-1:0];
            sat_o = 1'b1;
        end else if (qr < MINV) begin
            z_o   = MINV[D_W-1:0];
            sat_o = 1'b1;
        end else begin
            z_o   = qr[D_W-1:0];
            sat_o = 1'b0;
        end
    end

endmodule

// File: rtl/mult_add.sv
// Signed multiply-accumulate: p_o = a_i * b_i + c_i, wrapped to P_W bits.
//   a_i : A_W-bit signed multiplicand
//   b_i : B_W-bit signed multiplier
//   c_i : P_W-bit signed addend
//   p_o : P_W-bit signed result
module mult_add #(
    parameter int A_W = 26,
    parameter int B_W = 11,
    parameter int P_W = 36
) (
    input  logic signed [A_W-1:0] a_i,
    input  logic signed [B_W-1:0] b_i,
    input  logic signed [P_W-1:0] c_i,
    output logic signed [P_W-1:0] p_o
);

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;

    // Callers guarantee the true product fits in P_W, so the low P_W bits
    // of the extended multiply are exact.
    assign a_ext = P_W'(a_i);
    assign b_ext = P_W'(b_i);
    assign p_o   = a_ext * b_ext + c_i;

endmodule

// File: rtl/fft_r22sdf_cmul.sv
// Complex twiddle multiplier z = x * w (3-multiply Karatsuba form).
//   clk_i, rst_n         : clock, async active-low reset
//   valid_i / ready_o    : input handshake (ready_o tied high when SHARE=0)
//   ctr_i, x_*_i, w_*_i  : counter and operands of the sample
//   valid_o, ctr_o, z_*_o: registered result, 4 cycles after acceptance
//   ovf_o / clr_ovf_i    : sticky saturation flag and its clear (set wins)
// SHARE=0: three multipliers, one sample per cycle.
// SHARE=1: one multiplier stepped IDLE -> MF -> MR -> MI, one sample per 3 cycles.
//   state | meaning
//   IDLE  | waiting for a sample
//   MF    | f = w_re * (x_re - x_im)
//   MR    | R = x_im * (w_re - w_im) + f
//   MI    | I = x_re * (w_re + w_im) - f, next sample may be accepted
module fft_r22sdf_cmul
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH    = 25,
    parameter int TWIDDLE_WIDTH = 10,
    parameter int NLOG2         = 10,
    parameter int SHARE         = 0,
    parameter int ROUND         = ROUND_CONV
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [NLOG2-1:0]             ctr_i,
    input  logic signed [DATA_WIDTH-1:0] x_re_i,
    input  logic signed [DATA_WIDTH-1:0] x_im_i,
    input  logic signed [TWIDDLE_WIDTH-1:0] w_re_i,
    input  logic signed [TWIDDLE_WIDTH-1:0] w_im_i,
    output logic                         valid_o,
    output logic [NLOG2-1:0]             ctr_o,
    output logic signed [DATA_WIDTH-1:0] z_re_o,
    output logic signed [DATA_WIDTH-1:0] z_im_o,
    output logic                         ovf_o,
    input  logic                         clr_ovf_i
);

    localparam int P_W = cmul_prod_w(DATA_WIDTH, TWIDDLE_WIDTH);
    localparam int A_W = DATA_WIDTH + 1;
    localparam int B_W = TWIDDLE_WIDTH + 1;
    localparam int SH  = TWIDDLE_WIDTH - 1;

    logic                  out_v_d;
    logic [NLOG2-1:0]      out_ctr_d;
    logic signed [P_W-1:0] out_r_d;
    logic signed [P_W-1:0] out_i_d;
    logic signed [DATA_WIDTH-1:0] rs_re, rs_im;
    logic                  sat_re, sat_im;

    logic                  valid_q;
    logic [NLOG2-1:0]      ctr_q;
    logic signed [DATA_WIDTH-1:0] z_re_q, z_im_q;
    logic                  ovf_q;

    fft_round_sat #(.P_W(P_W), .D_W(DATA_WIDTH), .SH(SH), .ROUND(ROUND)) u_rs_re (
        .in_i(out_r_d), .z_o(rs_re), .sat_o(sat_re));
    fft_round_sat #(.P_W(P_W), .D_W(DATA_WIDTH), .SH(SH), .ROUND(ROUND)) u_rs_im (
        .in_i(out_i_d), .z_o(rs_im), .sat_o(sat_im));

    generate
        if (SHARE == 0) begin : g_par
            logic                  in_v_q, s1_v_q, s2_v_q, s3_v_q;
            logic [NLOG2-1:0]      in_ctr_q, s1_ctr_q, s2_ctr_q, s3_ctr_q;
            logic signed [DATA_WIDTH-1:0]    in_xre_q, in_xim_q;
            logic signed [TWIDDLE_WIDTH-1:0] in_wre_q, in_wim_q;
            logic signed [A_W-1:0] s1_xre_q, s1_xim_q, s1_e_q;
            logic signed [B_W-1:0] s1_wre_q, s1_wd_q, s1_ws_q;
            logic signed [P_W-1:0] m_f, m_r, m_i;
            logic signed [P_W-1:0] s2_f_q, s2_r_q, s2_i_q, s3_r_q, s3_i_q;

            assign ready_o = 1'b1;

            mult_add #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) u_mf (
                .a_i(s1_e_q), .b_i(s1_wre_q), .c_i('0), .p_o(m_f));
            mult_add #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) u_mr (
                .a_i(s1_xim_q), .b_i(s1_wd_q), .c_i('0), .p_o(m_r));
            mult_add #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) u_mi (
                .a_i(s1_xre_q), .b_i(s1_ws_q), .c_i('0), .p_o(m_i));

            always_ff @(posedge clk_i or negedge rst_n) begin
                if (!rst_n) begin
                    {in_v_q, s1_v_q, s2_v_q, s3_v_q} <= '0;
                    {in_ctr_q, s1_ctr_q, s2_ctr_q, s3_ctr_q} <= '0;
                    {in_xre_q, in_xim_q, in_wre_q, in_wim_q} <= '0;
                    {s1_xre_q, s1_xim_q, s1_e_q, s1_wre_q, s1_wd_q, s1_ws_q} <= '0;
                    {s2_f_q, s2_r_q, s2_i_q, s3_r_q, s3_i_q} <= '0;
                end else begin
                    in_v_q <= valid_i;
                    if (valid_i) begin
                        in_ctr_q <= ctr_i;
                        in_xre_q <= x_re_i;
                        in_xim_q <= x_im_i;
                        in_wre_q <= w_re_i;
                        in_wim_q <= w_im_i;
                    end
                    s1_v_q <= in_v_q;
                    if (in_v_q) begin
                        s1_ctr_q <= in_ctr_q;
                        s1_xre_q <= A_W'(in_xre_q);
                        s1_xim_q <= A_W'(in_xim_q);
                        s1_e_q   <= A_W'(in_xre_q) - A_W'(in_xim_q);
                        s1_wre_q <= B_W'(in_wre_q);
                        s1_wd_q  <= B_W'(in_wre_q) - B_W'(in_wim_q);
                        s1_ws_q  <= B_W'(in_wre_q) + B_W'(in_wim_q);
                    end
                    s2_v_q <= s1_v_q;
                    if (s1_v_q) begin
                        s2_ctr_q <= s1_ctr_q;
                        s2_f_q   <= m_f;
                        s2_r_q   <= m_r;
                        s2_i_q   <= m_i;
                    end
                    s3_v_q <= s2_v_q;
                    if (s2_v_q) begin
                        s3_ctr_q <= s2_ctr_q;
                        s3_r_q   <= s2_r_q + s2_f_q;
                        s3_i_q   <= s2_i_q - s2_f_q;
                    end
                end
            end

            assign out_v_d   = s3_v_q;
            assign out_ctr_d = s3_ctr_q;
            assign out_r_d   = s3_r_q;
            assign out_i_d   = s3_i_q;
        end else begin : g_shr
            cmul_state_e           state_q;
            logic [NLOG2-1:0]      ctr_in_q, res_ctr_q;
            logic signed [DATA_WIDTH-1:0]    x_re_q, x_im_q;
            logic signed [TWIDDLE_WIDTH-1:0] w_re_q, w_im_q;
            logic signed [P_W-1:0] f_q, r_q, i_q;
            logic                  res_v_q;
            logic                  accept;
            logic signed [A_W-1:0] ma;
            logic signed [B_W-1:0] mb;
            logic signed [P_W-1:0] mc, mp;

            assign ready_o = (state_q == ST_IDLE) || (state_q == ST_MI);
            assign accept  = valid_i & ready_o;

            always_comb begin
                ma = '0;
                mb = '0;
                mc = '0;
                case (state_q)
                    ST_MF: begin
                        ma = A_W'(x_re_q) - A_W'(x_im_q);
                        mb = B_W'(w_re_q);
                    end
                    ST_MR: begin
                        ma = A_W'(x_im_q);
                        mb = B_W'(w_re_q) - B_W'(w_im_q);
                        mc = f_q;
                    end
                    ST_MI: begin
                        ma = A_W'(x_re_q);
                        mb = B_W'(w_re_q) + B_W'(w_im_q);
                        mc = -f_q;
                    end
                    default: ;
                endcase
            end

            mult_add #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) u_m (
                .a_i(ma), .b_i(mb), .c_i(mc), .p_o(mp));

            // R and I stay put until the output edge; the next sample's MR
            // writes r_q no earlier than one cycle after that edge.
            always_ff @(posedge clk_i or negedge rst_n) begin
                if (!rst_n) begin
                    state_q   <= ST_IDLE;
                    {ctr_in_q, res_ctr_q} <= '0;
                    {x_re_q, x_im_q, w_re_q, w_im_q} <= '0;
                    {f_q, r_q, i_q} <= '0;
                    res_v_q   <= 1'b0;
                end else begin
                    res_v_q <= 1'b0;
                    if (accept) begin
                        ctr_in_q <= ctr_i;
                        x_re_q   <= x_re_i;
                        x_im_q   <= x_im_i;
                        w_re_q   <= w_re_i;
                        w_im_q   <= w_im_i;
                    end
                    case (state_q)
                        ST_IDLE: if (accept) state_q <= ST_MF;
                        ST_MF: begin
                            f_q     <= mp;
                            state_q <= ST_MR;
                        end
                        ST_MR: begin
                            r_q     <= mp;
                            state_q <= ST_MI;
                        end
                        ST_MI: begin
                            i_q       <= mp;
                            res_v_q   <= 1'b1;
                            res_ctr_q <= ctr_in_q;
                            state_q   <= accept ? ST_MF : ST_IDLE;
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end

            assign out_v_d   = res_v_q;
            assign out_ctr_d = res_ctr_q;
            assign out_r_d   = r_q;
            assign out_i_d   = i_q;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctr_q   <= '0;
            z_re_q  <= '0;
            z_im_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= out_v_d;
            if (out_v_d) begin
                ctr_q  <= out_ctr_d;
                z_re_q <= rs_re;
                z_im_q <= rs_im;
            end
            ovf_q <= (out_v_d & (sat_re | sat_im)) | (ovf_q & ~clr_ovf_i);
        end
    end

    assign valid_o = valid_q;
    assign ctr_o   = ctr_q;
    assign z_re_o  = z_re_q;
    assign z_im_o  = z_im_q;
    assign ovf_o   = ovf_q;

endmodule

// File: doc/fft_r22sdf_cmul.md
Name: fft_r22sdf_cmul

Overview:
Parametrised complex twiddle multiplier for the R2²SDF FFT pipeline. It computes z = x·w using the 3-multiply Karatsuba form, with valid/ready handshaking, selectable rounding, output saturation and a sticky overflow flag. A build-time mode selects either three parallel multipliers (one sample per cycle) or one shared multiplier (one sample per three cycles). The whole block runs on a single clock with no multiple-rate clock. It sits between butterfly stage pairs, and the FFT counter passes through alongside the data.

Parameters:
DATA_WIDTH, 25, signed width of x and z components
TWIDDLE_WIDTH, 10, signed width of w components; 2^(TWIDDLE_WIDTH-1) represents 1.0
NLOG2, 10, counter width (log2 FFT length)
SHARE, 0, 0 = three parallel multipliers (II=1); 1 = one time-shared multiplier (II=3)
ROUND, 1, 0 = truncate toward -inf; 1 = convergent (round half to even)

Ports:
clk_i  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_i  in  1  input sample valid
ready_o  out  1  block accepts the sample this cycle
ctr_i  in  NLOG2  FFT counter travelling with the sample
x_re_i, x_im_i  in  DATA_WIDTH  signed data
w_re_i, w_im_i  in  TWIDDLE_WIDTH  signed twiddle
valid_o  out  1  output valid, one-cycle pulse per accepted sample
ctr_o  out  NLOG2  counter aligned with z
z_re_o, z_im_o  out  DATA_WIDTH  signed product
ovf_o  out  1  sticky saturation flag
clr_ovf_i  in  1  clears ovf_o

Behaviour:
- Reset (asynchronous, rst_n=0): valid_o=0, ctr_o=0, z_re_o=z_im_o=0, ovf_o=0.
  - SHARE=1: FSM goes to IDLE and ready_o=1.
  - In-flight samples are discarded. No valid_o pulse appears for them after release.
- Handshake: a sample is accepted when valid_i & ready_o at a rising edge. The output has no backpressure; downstream always accepts.
- Karatsuba arithmetic: e = x_re - x_im; f = w_re·e; R = x_im·(w_re - w_im) + f; I = x_re·(w_re + w_im) - f.
  - Sums and differences are computed at full width, +1 bit.
  - Products are P = DATA_WIDTH+TWIDDLE_WIDTH+1 bits.
- Scaling: z = R, I shifted right by TWIDDLE_WIDTH-1, then rounded per ROUND.
- Saturation: result clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Any clamp on an output with valid_o=1 sets ovf_o.
  - clr_ovf_i clears ovf_o on the next edge.
  - Simultaneous set and clear: set wins.
- Latency is 4 cycles in both modes: acceptance at edge t gives valid_o=1 in the cycle after edge t+4. ctr_o and z update with valid_o and hold when valid_o=0.
- SHARE=0: ready_o is tied to 1. Four register stages:
  - S1: capture inputs; compute e, w_re-w_im, w_re+w_im.
  - S2: three products.
  - S3: add/sub f.
  - S4: round/saturate.
  - A valid bit travels with each stage. Back-to-back samples are allowed every cycle.
- SHARE=1: FSM states IDLE, MF, MR, MI.
  - Inputs are registered on acceptance, so sources may change afterwards.
  - Per state: MF computes f; MR computes R using accumulate input f; MI computes I using accumulate input -f. The result is registered, giving valid_o next cycle.
  - Transitions: IDLE→MF on accept; MF→MR; MR→MI; MI→MF if accept, else IDLE.
  - ready_o=1 only in IDLE and MI, giving II=3 under continuous valid_i.
  - valid_i seen in MF or MR is not accepted; the source must hold it.

Decomposition:
- Shared package fft_pkg holds:
  - ROUND_TRUNC=0 and ROUND_CONV=1 constants
  - the cmul FSM state encoding (IDLE/MF/MR/MI)
  - a width function for P
- Reuse existing mult_add for every multiply (one instance when SHARE=1, three when SHARE=0).
- One new combinational sub-module, fft_round_sat (P-bit in; shift, round, saturate; DATA_WIDTH out plus a sat flag). Future butterfly stages reuse it.

Test Plan:
- SHARE=0: x=(1000,-2000), w=(256,0) → z=(500,-1000), valid_o exactly 4 cycles after accept, ctr_o equals ctr_i.
- w=(-512,0), x=(100,50) → z=(-100,-50); w=(0,-512), x=(100,50) → z=(50,-100).
- Rounding with w=(256,0):
  - ROUND=0: x=(3,0)→1, x=(-3,0)→-2.
  - ROUND=1: x=(3,0)→2, x=(1,0)→0, x=(-3,0)→-2.
- Saturation: x=(2^24-1, 2^24-1), w=(-512,-512) → z_re=0, z_im=-2^24, ovf_o=1.
  - ovf_o stays high over later clean samples.
  - clr_ovf_i pulse clears it.
  - clr_ovf_i together with another saturating output leaves it at 1.
- SHARE=1: valid_i held high 9 cycles from IDLE → ready_o pattern 1,0,0,1,0,0,1,0,0; three samples accepted; valid_o pulses spaced 3 cycles apart; z and ctr values match a golden model.
- rst_n pulsed low 2 cycles after an accept (both modes) → outputs zero immediately, no valid_o for the dropped sample, correct result for the first sample accepted after release.
